// File: rtl/uart_pkg.sv
// Shared UART constants, state encoding and counter-load helper for the rx and tx paths.
// Parity states exist only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int OVERSAMPLE = 8;
    localparam int BIT_SHIFT  = $clog2(OVERSAMPLE);
    localparam int HALF_SHIFT = BIT_SHIFT - 1;
    localparam int CNT_W      = 16 + BIT_SHIFT;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } uart_state_t;

    // Down-counter reload for (pre << shift) clock cycles.
    function automatic logic [CNT_W-1:0] period_load(input logic [15:0] pre, input int unsigned shift);
        return (CNT_W'(pre) << shift) - CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-word stream: producer drives tdata/tvalid, consumer drives tready.
// A word transfers on any cycle where tvalid && tready.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous level; two cycles of latency.
// No backpressure; the reset value is a parameter so idle-high lines do not fake an edge.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8x oversampled; word valid the cycle after the stop-bit sample. Optional parity: UART_RX_PARITY_EN.
// No backpressure on the line: an unconsumed word is overwritten and overrun_error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    uart_rx_if.master   m_axis,
    input  logic        rxd,
    output logic        busy,
    output logic        overrun_error,
    output logic        frame_error,
`ifdef UART_RX_PARITY_EN
    input  logic        parity_odd,
    output logic        parity_error,
`endif
    input  logic [15:0] prescale
);

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic                  w_rxd;
    logic [15:0]           w_prescale;
    logic                  w_tick;
    logic                  w_word_ok;

    uart_state_t           r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [15:0]           r_prescale;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_busy;
    logic                  r_overrun;
    logic                  r_frame_err;
    logic                  r_rxd_prev;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rxd),
        .o_q (w_rxd)
    );

    assign w_prescale = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_tick     = (r_cnt == '0);

`ifdef UART_RX_PARITY_EN
    logic r_parity_bad;
    logic r_parity_err;
    assign w_word_ok    = w_rxd && !r_parity_bad;
    assign parity_error = r_parity_err;
`else
    assign w_word_ok    = w_rxd;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_prescale  <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rxd_prev  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_parity_bad <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rxd_prev  <= w_rxd;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (r_tvalid && m_axis.tready) r_tvalid <= 1'b0;
            if (r_state != IDLE && !w_tick) r_cnt <= r_cnt - CNT_W'(1);

            case (r_state)
                IDLE: begin
                    // Edge detect needs a high sample first, so a stuck-low line never retriggers.
                    if (r_rxd_prev && !w_rxd) begin
                        r_prescale <= w_prescale;
                        r_cnt      <= period_load(w_prescale, HALF_SHIFT);
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (!w_rxd) begin
                            r_cnt     <= period_load(r_prescale, BIT_SHIFT);
                            r_bit_idx <= '0;
                            r_state   <= DATA;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= {w_rxd, r_shift[DATA_WIDTH-1:1]};
                        r_cnt     <= period_load(r_prescale, BIT_SHIFT);
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
`ifdef UART_RX_PARITY_EN
                        if (r_bit_idx == LAST_IDX) r_state <= PARITY;
`else
                        if (r_bit_idx == LAST_IDX) r_state <= STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_parity_bad <= ((^r_shift) ^ w_rxd) != parity_odd;
                        r_cnt        <= period_load(r_prescale, BIT_SHIFT);
                        r_state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                        r_frame_err <= !w_rxd;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_parity_bad;
`endif
                        if (w_word_ok) begin
                            r_tdata   <= r_shift;
                            r_tvalid  <= 1'b1;
                            r_overrun <= r_tvalid && !m_axis.tready;
                        end
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_axis.tdata   = r_tdata;
    assign m_axis.tvalid  = r_tvalid;
    assign busy           = r_busy;
    assign overrun_error  = r_overrun;
    assign frame_error    = r_frame_err;

endmodule
